// File: rtl/nms_pkg.sv
// rtl/nms_pkg.sv - shared types, tap indices and neighbour lookup for non-maximum suppression
package nms_pkg;

    typedef enum logic [1:0] {
        DIR_H    = 2'd0,
        DIR_D45  = 2'd1,
        DIR_V    = 2'd2,
        DIR_D135 = 2'd3
    } nms_dir_e;

    // Window taps, row-major: k = row*3 + col
    localparam int TAP_NW   = 0;
    localparam int TAP_N    = 1;
    localparam int TAP_NE   = 2;
    localparam int TAP_W    = 3;
    localparam int TAP_C    = 4;
    localparam int TAP_E    = 5;
    localparam int TAP_SW   = 6;
    localparam int TAP_S    = 7;
    localparam int TAP_SE   = 8;
    localparam int NUM_TAPS = 9;

    typedef struct packed {
        logic [3:0] back;
        logic [3:0] fwd;
    } nbr_pair_t;

    function automatic nbr_pair_t nbr_pair(input nms_dir_e dir);
        nbr_pair_t p;
        case (dir)
            DIR_H:    begin p.back = 4'(TAP_W);  p.fwd = 4'(TAP_E);  end
            DIR_D45:  begin p.back = 4'(TAP_NW); p.fwd = 4'(TAP_SE); end
            DIR_V:    begin p.back = 4'(TAP_N);  p.fwd = 4'(TAP_S);  end
            default:  begin p.back = 4'(TAP_NE); p.fwd = 4'(TAP_SW); end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/nms_core.sv
// rtl/nms_core.sv - combinational kill decision for one centre pixel
import nms_pkg::*;

module nms_core #(
    parameter int MAG_W    = 11,
    parameter int TIE_MODE = 0
) (
    input  logic [9*MAG_W-1:0] win,
    input  logic [1:0]         dir,
    output logic [MAG_W-1:0]   centre,
    output logic               kill
);

    logic [MAG_W-1:0] taps [NUM_TAPS];
    nbr_pair_t        pair;
    logic [MAG_W-1:0] back_mag;
    logic [MAG_W-1:0] fwd_mag;
    logic             back_kill;
    logic             fwd_kill;

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_taps
        assign taps[k] = win[k*MAG_W +: MAG_W];
    end

    always_comb begin
        pair      = nbr_pair(nms_dir_e'(dir));
        centre    = taps[TAP_C];
        back_mag  = taps[pair.back];
        fwd_mag   = taps[pair.fwd];
        back_kill = (centre <= back_mag);
        // Mode 1 lets a centre survive a tie with its forward neighbour only
        if (TIE_MODE == 1) begin
            fwd_kill = (centre < fwd_mag);
        end else begin
            fwd_kill = (centre <= fwd_mag);
        end
        kill = back_kill || fwd_kill;
    end

endmodule

// File: rtl/nms_pipe.sv
// rtl/nms_pipe.sv - two-stage NMS pipeline with backpressure, thresholds and per-frame survivor count
import nms_pkg::*;

module nms_pipe #(
    parameter int MAG_W    = 11,
    parameter int TIE_MODE = 0,
    parameter int CNT_W    = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9*MAG_W-1:0] in_mag_win,
    input  logic [1:0]         in_dir,
    input  logic               in_sof,
    input  logic               in_eof,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAG_W-1:0]   thresh_low,
    input  logic [MAG_W-1:0]   thresh_high,
    output logic [MAG_W-1:0]   out_mag,
    output logic [1:0]         out_dir,
    output logic               out_strong,
    output logic               out_sof,
    output logic               out_eof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   frame_count,
    output logic               frame_done
);

    logic             adv;
    logic [MAG_W-1:0] core_centre;
    logic             core_kill;

    logic             s1_valid;
    logic [MAG_W-1:0] s1_centre;
    logic             s1_kill;
    logic [1:0]       s1_dir;
    logic             s1_sof;
    logic             s1_eof;

    logic [MAG_W-1:0] s2_mag;
    logic             s2_strong;

    logic             out_fire;
    logic             survivor;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_next;

    nms_core #(
        .MAG_W    (MAG_W),
        .TIE_MODE (TIE_MODE)
    ) u_core (
        .win    (in_mag_win),
        .dir    (in_dir),
        .centre (core_centre),
        .kill   (core_kill)
    );

    // Single advance enable: the whole pipe moves together or freezes together
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        if (s1_kill || (s1_centre < thresh_low)) begin
            s2_mag = '0;
        end else begin
            s2_mag = s1_centre;
        end
        s2_strong = (s2_mag != '0) && (s2_mag >= thresh_high);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_centre <= '0;
            s1_kill   <= 1'b0;
            s1_dir    <= 2'd0;
            s1_sof    <= 1'b0;
            s1_eof    <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_centre <= core_centre;
            s1_kill   <= core_kill;
            s1_dir    <= in_dir;
            s1_sof    <= in_valid && in_sof;
            s1_eof    <= in_valid && in_eof;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_mag    <= '0;
            out_dir    <= 2'd0;
            out_strong <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
        end else if (adv) begin
            out_valid  <= s1_valid;
            out_mag    <= s2_mag;
            out_dir    <= s1_dir;
            out_strong <= s2_strong;
            out_sof    <= s1_sof;
            out_eof    <= s1_eof;
        end
    end

    assign out_fire = out_valid && out_ready;
    assign survivor = (out_mag != '0);

    // Count including the beat currently being accepted, so eof can latch it directly
    always_comb begin
        if (out_sof) begin
            run_next = {{(CNT_W-1){1'b0}}, survivor};
        end else if (survivor && (run_cnt != '1)) begin
            run_next = run_cnt + CNT_W'(1);
        end else begin
            run_next = run_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt     <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_fire) begin
                run_cnt <= run_next;
                if (out_eof) begin
                    frame_count <= run_next;
                    frame_done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nms_pipe.sv
// tb/tb_nms_pipe.sv - scoreboard bench for nms_pipe, both tie modes run in lockstep
module tb_nms_pipe;

    localparam int MAG_W = 11;
    localparam int CNT_W = 20;
    localparam int WIN_W = 9 * MAG_W;

    typedef struct {
        int       mag0;
        int       mag1;
        int       st0;
        int       st1;
        int       dir;
        int       sof;
        int       eof;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIN_W-1:0]   in_mag_win;
    logic [1:0]         in_dir;
    logic               in_sof;
    logic               in_eof;
    logic               in_valid;
    logic [MAG_W-1:0]   thresh_low;
    logic [MAG_W-1:0]   thresh_high;
    logic               out_ready;

    logic               rdy0, rdy1;
    logic [MAG_W-1:0]   mag0, mag1;
    logic [1:0]         dir0, dir1;
    logic               st0, st1, sof0, sof1, eof0, eof1, v0, v1, fd0, fd1;
    logic [CNT_W-1:0]   fc0, fc1;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   fq[$];
    bit   mon_en = 1'b0;
    bit   pat_en = 1'b0;
    logic [3:0] pat = 4'b1001;
    int   pi = 0;

    nms_pipe #(.MAG_W(MAG_W), .TIE_MODE(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .in_mag_win(in_mag_win), .in_dir(in_dir), .in_sof(in_sof),
        .in_eof(in_eof), .in_valid(in_valid), .in_ready(rdy0), .thresh_low(thresh_low),
        .thresh_high(thresh_high), .out_mag(mag0), .out_dir(dir0), .out_strong(st0),
        .out_sof(sof0), .out_eof(eof0), .out_valid(v0), .out_ready(out_ready),
        .frame_count(fc0), .frame_done(fd0)
    );

    nms_pipe #(.MAG_W(MAG_W), .TIE_MODE(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .in_mag_win(in_mag_win), .in_dir(in_dir), .in_sof(in_sof),
        .in_eof(in_eof), .in_valid(in_valid), .in_ready(rdy1), .thresh_low(thresh_low),
        .thresh_high(thresh_high), .out_mag(mag1), .out_dir(dir1), .out_strong(st1),
        .out_sof(sof1), .out_eof(eof1), .out_valid(v1), .out_ready(out_ready),
        .frame_count(fc1), .frame_done(fd1)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] mk(input int bi, input int fi, input int c, input int b, input int f);
        logic [WIN_W-1:0] w;
        w = '0;
        w[4*MAG_W +: MAG_W]  = MAG_W'(c);
        w[bi*MAG_W +: MAG_W] = MAG_W'(b);
        w[fi*MAG_W +: MAG_W] = MAG_W'(f);
        return w;
    endfunction

    task automatic send(input logic [WIN_W-1:0] win, input int dir, input int sof, input int eof,
                        input int m0, input int m1, input int s0, input int s1, input int fexp);
        int   guard;
        exp_t e;
        in_mag_win = win;
        in_dir     = 2'(dir);
        in_sof     = 1'(sof);
        in_eof     = 1'(eof);
        in_valid   = 1'b1;
        guard      = 0;
        @(negedge clk);
        while (!rdy0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 0, 1);
        e = '{mag0: m0, mag1: m1, st0: s0, st1: s1, dir: dir, sof: sof, eof: eof};
        sb.push_back(e);
        if (eof != 0) fq.push_back(fexp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || fq.size() != 0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("drain_timeout", 0, 1);
        idle(2);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (pat_en) begin
            out_ready = pat[pi];
            pi = (pi + 1) % 4;
        end
    end

    exp_t me;
    int   mf;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("in_ready_adv", rdy0, (!v0 || out_ready));
            check("in_ready_lockstep", rdy1, rdy0);
            if (v0 && out_ready) begin
                check("valid_lockstep", v1, 1);
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    me = sb.pop_front();
                    check("mag_tie0", mag0, me.mag0);
                    check("mag_tie1", mag1, me.mag1);
                    check("strong_tie0", st0, me.st0);
                    check("strong_tie1", st1, me.st1);
                    check("dir", dir0, me.dir);
                    check("sof", sof0, me.sof);
                    check("eof", eof0, me.eof);
                end
            end
            if (fd0 || fd1) begin
                check("frame_done_lockstep", fd1, fd0);
                if (fq.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    mf = fq.pop_front();
                    check("frame_count_tie0", fc0, mf);
                    check("frame_count_tie1", fc1, mf);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    int bi[4] = '{3, 0, 1, 2};
    int fi[4] = '{5, 8, 7, 6};
    int cen[8] = '{50, 10, 70, 20, 40, 5, 90, 35};
    int em[8]  = '{50, 0, 70, 0, 40, 0, 90, 35};
    int es[8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
    logic [WIN_W-1:0] w;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mag_win = '0; in_dir = 2'd0; in_sof = 1'b0; in_eof = 1'b0;
        out_ready = 1'b1; thresh_low = '0; thresh_high = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", v0, 0);
        check("rst_out_mag", mag0, 0);
        check("rst_out_dir", dir0, 0);
        check("rst_out_strong", st0, 0);
        check("rst_out_sof_eof", {sof0, eof0}, 0);
        check("rst_frame_count", fc0, 0);
        check("rst_frame_done", fd0, 0);
        check("rst_in_ready", rdy0, 1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Tie handling: mode 0 kills an equal forward neighbour, mode 1 keeps it
        send(mk(3, 5, 20, 10, 15), 0, 0, 0, 20, 20, 1, 1, 0);
        send(mk(3, 5, 20, 10, 20), 0, 0, 0, 0, 20, 0, 1, 0);

        for (int d = 0; d < 4; d++) begin
            send(mk(bi[d], fi[d], 50, 49, 51), d, 0, 0, 0, 0, 0, 0, 0);
            send(mk(bi[d], fi[d], 50, 49, 49), d, 0, 0, 50, 50, 1, 1, 0);
        end
        w = mk(0, 8, 50, 49, 49);
        w[3*MAG_W +: MAG_W] = 11'd99;
        send(w, 1, 0, 0, 50, 50, 1, 1, 0);
        drain();

        thresh_low = 11'd30; thresh_high = 11'd60;
        send(mk(3, 5, 25, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
        send(mk(3, 5, 40, 0, 0), 0, 0, 0, 40, 40, 0, 0, 0);
        send(mk(3, 5, 60, 0, 0), 0, 0, 0, 60, 60, 1, 1, 0);
        drain();

        thresh_low = '0; thresh_high = '0;
        pat_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            send(mk(1, 7, i, 0, 0), 2, 0, 0, i, i, 1, 1, 0);
        end
        drain();
        @(negedge clk);
        pat_en = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        thresh_low = 11'd30; thresh_high = 11'd60;
        for (int i = 0; i < 8; i++) begin
            send(mk(3, 5, cen[i], 0, 0), 0, (i == 0) ? 1 : 0, (i == 7) ? 1 : 0,
                 em[i], em[i], es[i], es[i], 5);
            if (i == 3) idle(2);
        end
        send(mk(3, 5, 45, 0, 0), 0, 1, 1, 45, 45, 0, 0, 1);
        drain();

        // Two beats held in flight by backpressure, then a one-cycle reset
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(mk(3, 5, 80, 0, 0), 0, 1, 0, 80, 80, 1, 1, 0);
        send(mk(3, 5, 70, 0, 0), 0, 0, 0, 70, 70, 1, 1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", v0, 0);
        check("midrst_out_valid_tie1", v1, 0);
        check("midrst_frame_count", fc0, 0);
        check("midrst_frame_done", fd0, 0);
        check("midrst_in_ready", rdy0, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(mk(3, 5, 80, 0, 0), 0, 1, 0, 80, 80, 1, 1, 0);
        send(mk(3, 5, 10, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
        send(mk(3, 5, 33, 0, 0), 0, 0, 1, 33, 33, 0, 0, 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
